// File: rtl/ham_pkg.sv
// Shared constants and FSM state type for the Hamming (17,12) receive path.
package ham_pkg;

  localparam int HAM_CW_W   = 17;
  localparam int HAM_DATA_W = 12;
  localparam int HAM_SYN_W  = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/ham_rx_deserializer_if.sv
// Bundle between the serial channel / codeword consumer (master) and the deserializer (slave).
// Optional HAM_RX_SYNDROME_EN adds cw_syndrome and cw_err.
interface ham_rx_deserializer_if
  import ham_pkg::*;
#(
  parameter int CW_W = 17
) ();

  // Handshake: a bit is taken on every clock with rx_valid=1 (no back-pressure on the
  // serial side); a codeword moves on every clock with cw_valid=1 and cw_ready=1, and
  // cw_data holds steady while cw_valid=1 and cw_ready=0.
  logic            rx_bit;
  logic            rx_valid;
  logic            rx_sof;
  logic [CW_W-1:0] cw_data;
  logic            cw_valid;
  logic            cw_ready;
  logic            busy;
  logic            frame_abort;
  logic            overflow;
`ifdef HAM_RX_SYNDROME_EN
  logic [HAM_SYN_W-1:0] cw_syndrome;
  logic                 cw_err;
`endif

  modport master (
    output rx_bit, rx_valid, rx_sof, cw_ready,
`ifdef HAM_RX_SYNDROME_EN
    input  cw_syndrome, cw_err,
`endif
    input  cw_data, cw_valid, busy, frame_abort, overflow
  );

  modport slave (
    input  rx_bit, rx_valid, rx_sof, cw_ready,
`ifdef HAM_RX_SYNDROME_EN
    output cw_syndrome, cw_err,
`endif
    output cw_data, cw_valid, busy, frame_abort, overflow
  );

endinterface

// File: rtl/ham_syndrome17.sv
// Combinational Hamming (17,12) syndrome: XOR of (i+1) over every set codeword bit i.
// Only built when HAM_RX_SYNDROME_EN is defined.
`ifdef HAM_RX_SYNDROME_EN
module ham_syndrome17
  import ham_pkg::*;
(
  input  logic [HAM_CW_W-1:0]  cw_i,
  output logic [HAM_SYN_W-1:0] syn_o
);

  always_comb begin
    syn_o = '0;
    for (int i = 0; i < HAM_CW_W; i++) begin
      if (cw_i[i]) syn_o = syn_o ^ HAM_SYN_W'(i + 1);
    end
  end

endmodule
`endif

// File: rtl/ham_rx_deserializer.sv
// Frames a strobed serial stream into CW_W-bit codewords behind a one-entry valid/ready buffer.
// Optional HAM_RX_SYNDROME_EN registers a Hamming syndrome and error flag with each codeword.
module ham_rx_deserializer
  import ham_pkg::*;
#(
  parameter int CW_W      = HAM_CW_W,
  parameter bit LSB_FIRST = 1'b1,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  ham_rx_deserializer_if.slave bus,
  output state_t               dbg_state_o
);

  localparam int              CNT_W      = $clog2(CW_W + 1);
  localparam int              GAP_W      = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(CW_W - 1);
  localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(TIMEOUT - 1);
  localparam logic [CW_W-1:0]  FIRST_MASK = LSB_FIRST ? CW_W'(1) : {1'b1, {(CW_W-1){1'b0}}};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [CW_W-1:0]  sreg_q, sreg_d;
  logic [CW_W-1:0]  data_q, data_d;
  logic             valid_q, valid_d;
  logic             abort_q, abort_d;
  logic             ovf_q, ovf_d;

  logic [CW_W-1:0] bit_mask, word_next, sof_word;
  logic            take_bit, sof_bit, complete, buf_free, load;

  // The mirrored order just walks the one-hot insert mask from the other end.
  assign bit_mask  = LSB_FIRST ? (FIRST_MASK << cnt_q) : (FIRST_MASK >> cnt_q);
  assign word_next = bus.rx_bit ? (sreg_q | bit_mask) : (sreg_q & ~bit_mask);
  assign sof_word  = bus.rx_bit ? FIRST_MASK : '0;
  assign take_bit  = bus.rx_valid & ~bus.rx_sof;
  assign sof_bit   = bus.rx_valid & bus.rx_sof;
  assign complete  = (state_q == SHIFT) & take_bit & (cnt_q == LAST_IDX);
  assign buf_free  = ~valid_q | bus.cw_ready;
  assign load      = complete & buf_free;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      sreg_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      abort_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      sreg_q  <= sreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      abort_q <= abort_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    sreg_d  = sreg_q;
    abort_d = 1'b0;
    ovf_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (sof_bit) begin
          state_d = SHIFT;
          cnt_d   = CNT_W'(1);
          gap_d   = '0;
          sreg_d  = sof_word;
        end
      end
      SHIFT: begin
        if (sof_bit) begin
          abort_d = 1'b1;
          cnt_d   = CNT_W'(1);
          gap_d   = '0;
          sreg_d  = sof_word;
        end else if (take_bit) begin
          gap_d  = '0;
          sreg_d = word_next;
          if (complete) begin
            state_d = IDLE;
            cnt_d   = '0;
            ovf_d   = ~buf_free;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (gap_q == GAP_LIMIT) begin
          abort_d = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A same-cycle drain and reload keeps cw_valid high with fresh data.
  always_comb begin
    data_d  = load ? word_next : data_q;
    valid_d = load | (valid_q & ~bus.cw_ready);
  end

  always_comb begin
    bus.cw_data     = data_q;
    bus.cw_valid    = valid_q;
    bus.busy        = (state_q == SHIFT);
    bus.frame_abort = abort_q;
    bus.overflow    = ovf_q;
    dbg_state_o     = state_q;
  end

`ifdef HAM_RX_SYNDROME_EN
  logic [HAM_SYN_W-1:0] syn_next, syn_q;

  if (CW_W != HAM_CW_W) begin : g_bad_width
    $error("HAM_RX_SYNDROME_EN needs CW_W == 17");
  end

  ham_syndrome17 u_syndrome (
    .cw_i  (word_next),
    .syn_o (syn_next)
  );

  always_ff @(posedge clk) begin
    if (rst) syn_q <= '0;
    else if (load) syn_q <= syn_next;
  end

  assign bus.cw_syndrome = syn_q;
  assign bus.cw_err      = (syn_q != '0);
`endif

endmodule

// File: tb/tb_ham_rx_deserializer.sv
// Self-checking bench for ham_rx_deserializer (LSB-first, CW_W=17, TIMEOUT=64).
// Syndrome checks are compiled in when HAM_RX_SYNDROME_EN is defined.
module tb_ham_rx_deserializer;
  import ham_pkg::*;

  localparam int CW_W    = 17;
  localparam int TIMEOUT = 64;

  logic   clk = 1'b0;
  logic   rst;
  state_t dbg_state;

  int checks = 0;
  int errors = 0;
  int abort_cnt = 0;
  int ovf_cnt = 0;
  logic [CW_W-1:0] exp_q[$];
  logic [CW_W-1:0] got_q[$];

  ham_rx_deserializer_if #(.CW_W(CW_W)) bus ();

  ham_rx_deserializer #(
    .CW_W      (CW_W),
    .LSB_FIRST (1'b1),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // Monitor: records transfers and pulses between clock edges
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.cw_valid && bus.cw_ready) got_q.push_back(bus.cw_data);
      if (bus.frame_abort) abort_cnt++;
      if (bus.overflow) ovf_cnt++;
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b, input logic sof);
    bus.rx_bit   = b;
    bus.rx_valid = 1'b1;
    bus.rx_sof   = sof;
    tick();
    bus.rx_bit   = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_sof   = 1'b0;
  endtask

  task automatic send_bits(input logic [CW_W-1:0] w, input int n);
    for (int i = 0; i < n; i++) drive_bit(w[i], i == 0);
  endtask

  task automatic clear_scoreboard();
    exp_q.delete();
    got_q.delete();
    abort_cnt = 0;
    ovf_cnt   = 0;
  endtask

  task automatic compare_queues(input string name);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL %s_count got %0d words exp %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s_word[%0d] got %h exp %h", name, i, got_q[i], exp_q[i]);
      end
    end
  endtask

  // Reference encoder: data in non-power-of-two positions, parity chosen to zero the syndrome
  function automatic logic [16:0] ham_encode(input logic [11:0] d);
    logic [16:0] cw;
    logic [4:0]  s;
    int k;
    cw = '0;
    s  = '0;
    k  = 0;
    for (int p = 1; p <= 17; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p-1] = d[k];
        k++;
      end
    end
    for (int i = 0; i < 17; i++) if (cw[i]) s = s ^ 5'(i + 1);
    for (int b = 0; b < 5; b++) if (s[b]) cw[(1 << b) - 1] = 1'b1;
    return cw;
  endfunction

  // Tests
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (bus.cw_valid !== 1'b0 || bus.cw_data !== '0) begin
      errors++;
      $display("FAIL reset_buf got valid=%b data=%h exp valid=0 data=0", bus.cw_valid, bus.cw_data);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.frame_abort !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got busy=%b abort=%b ovf=%b exp 0 0 0", bus.busy, bus.frame_abort, bus.overflow);
    end
    checks++;
    if (dbg_state !== IDLE) begin
      errors++;
      $display("FAIL reset_state got %0d exp IDLE", dbg_state);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_clean_frame();
    clear_scoreboard();
    bus.cw_ready = 1'b1;
    send_bits(17'h1A5A3, CW_W);
    exp_q.push_back(17'h1A5A3);
    checks++;
    if (bus.cw_valid !== 1'b1 || bus.cw_data !== 17'h1A5A3) begin
      errors++;
      $display("FAIL clean_latency got valid=%b data=%h exp valid=1 data=1a5a3", bus.cw_valid, bus.cw_data);
    end
    tick();
    checks++;
    if (bus.cw_valid !== 1'b0) begin
      errors++;
      $display("FAIL clean_pulse got valid=%b exp 0", bus.cw_valid);
    end
    tick();
    compare_queues("clean");
    checks++;
    if (abort_cnt !== 0 || ovf_cnt !== 0) begin
      errors++;
      $display("FAIL clean_flags got abort=%0d ovf=%0d exp 0 0", abort_cnt, ovf_cnt);
    end
  endtask

  task automatic test_backpressure();
    clear_scoreboard();
    bus.cw_ready = 1'b0;
    send_bits(17'h00001, CW_W);
    send_bits(17'h1FFFF, CW_W);
    checks++;
    if (bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL bp_ovf_pulse got %b exp 1", bus.overflow);
    end
    send_bits(17'h0AAAA, CW_W);
    tick();
    checks++;
    if (ovf_cnt !== 2) begin
      errors++;
      $display("FAIL bp_ovf_count got %0d exp 2", ovf_cnt);
    end
    checks++;
    if (bus.cw_valid !== 1'b1 || bus.cw_data !== 17'h00001) begin
      errors++;
      $display("FAIL bp_hold got valid=%b data=%h exp valid=1 data=00001", bus.cw_valid, bus.cw_data);
    end
    bus.cw_ready = 1'b1;
    exp_q.push_back(17'h00001);
    tick();
    checks++;
    if (bus.cw_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain got valid=%b exp 0", bus.cw_valid);
    end
    tick();
    compare_queues("bp");
  endtask

  task automatic test_same_cycle_drain();
    logic [CW_W-1:0] w;
    clear_scoreboard();
    bus.cw_ready = 1'b0;
    send_bits(17'h12345, CW_W);
    w = 17'h0F0F0;
    for (int i = 0; i < CW_W - 1; i++) drive_bit(w[i], i == 0);
    bus.cw_ready = 1'b1;
    drive_bit(w[CW_W-1], 1'b0);
    exp_q.push_back(17'h12345);
    exp_q.push_back(17'h0F0F0);
    checks++;
    if (bus.cw_valid !== 1'b1 || bus.cw_data !== 17'h0F0F0) begin
      errors++;
      $display("FAIL drain_reload got valid=%b data=%h exp valid=1 data=0f0f0", bus.cw_valid, bus.cw_data);
    end
    tick();
    checks++;
    if (bus.cw_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty got valid=%b exp 0", bus.cw_valid);
    end
    compare_queues("drain");
    checks++;
    if (ovf_cnt !== 0) begin
      errors++;
      $display("FAIL drain_ovf got %0d exp 0", ovf_cnt);
    end
  endtask

  task automatic test_mid_frame_sof();
    clear_scoreboard();
    bus.cw_ready = 1'b1;
    send_bits(17'h1C3C3, 9);
    send_bits(17'h15555, CW_W);
    exp_q.push_back(17'h15555);
    repeat (2) tick();
    compare_queues("midsof");
    checks++;
    if (abort_cnt !== 1) begin
      errors++;
      $display("FAIL midsof_abort got %0d exp 1", abort_cnt);
    end
  endtask

  task automatic test_timeout();
    clear_scoreboard();
    bus.cw_ready = 1'b1;
    send_bits(17'h0001F, 5);
    repeat (TIMEOUT - 1) tick();
    checks++;
    if (bus.busy !== 1'b1 || bus.frame_abort !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early got busy=%b abort=%b exp 1 0", bus.busy, bus.frame_abort);
    end
    tick();
    checks++;
    if (bus.frame_abort !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_fire got abort=%b busy=%b exp 1 0", bus.frame_abort, bus.busy);
    end
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_ignore got busy=%b exp 0", bus.busy);
    end
    send_bits(17'h0BEEF, CW_W);
    exp_q.push_back(17'h0BEEF);
    repeat (2) tick();
    compare_queues("timeout");
    checks++;
    if (abort_cnt !== 1) begin
      errors++;
      $display("FAIL timeout_abort_count got %0d exp 1", abort_cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_scoreboard();
    bus.cw_ready = 1'b0;
    send_bits(17'h0ABCD, CW_W);
    send_bits(17'h1F00F, 10);
    rst = 1'b1;
    tick();
    checks++;
    if (bus.cw_valid !== 1'b0 || bus.cw_data !== '0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_outputs got valid=%b data=%h busy=%b exp 0 0 0", bus.cw_valid, bus.cw_data, bus.busy);
    end
    rst = 1'b0;
    repeat (3) tick();
    checks++;
    if (abort_cnt !== 0 || ovf_cnt !== 0 || bus.cw_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_quiet got abort=%0d ovf=%0d valid=%b exp 0 0 0", abort_cnt, ovf_cnt, bus.cw_valid);
    end
    bus.cw_ready = 1'b1;
    tick();
    compare_queues("rstmid");
  endtask

`ifdef HAM_RX_SYNDROME_EN
  task automatic test_syndrome();
    logic [16:0] cw;
    clear_scoreboard();
    bus.cw_ready = 1'b0;
    cw = ham_encode(12'($urandom_range(0, 4095)));
    send_bits(cw, CW_W);
    checks++;
    if (bus.cw_syndrome !== 5'd0 || bus.cw_err !== 1'b0) begin
      errors++;
      $display("FAIL syn_clean got syn=%0d err=%b exp 0 0", bus.cw_syndrome, bus.cw_err);
    end
    bus.cw_ready = 1'b1;
    tick();
    bus.cw_ready = 1'b0;
    cw[5] = ~cw[5];
    send_bits(cw, CW_W);
    checks++;
    if (bus.cw_syndrome !== 5'd6 || bus.cw_err !== 1'b1 || bus.cw_data !== cw) begin
      errors++;
      $display("FAIL syn_pos6 got syn=%0d err=%b data=%h exp 6 1 %h", bus.cw_syndrome, bus.cw_err, bus.cw_data, cw);
    end
    bus.cw_ready = 1'b1;
    repeat (2) tick();
  endtask
`endif

  task automatic test_random();
    logic [CW_W-1:0] w;
    int exp_aborts;
    clear_scoreboard();
    bus.cw_ready = 1'b1;
    exp_aborts = 0;
    for (int f = 0; f < 40; f++) begin
      for (int n = $urandom_range(0, 3); n > 0; n--) drive_bit(1'($urandom_range(0, 1)), 1'b0);
      if ($urandom_range(0, 4) == 0) begin
        send_bits(CW_W'($urandom), $urandom_range(1, CW_W - 1));
        exp_aborts++;
      end
      w = CW_W'($urandom);
      for (int i = 0; i < CW_W; i++) begin
        drive_bit(w[i], i == 0);
        repeat ($urandom_range(0, 3)) tick();
      end
      exp_q.push_back(w);
    end
    repeat (3) tick();
    compare_queues("random");
    checks++;
    if (abort_cnt !== exp_aborts || ovf_cnt !== 0) begin
      errors++;
      $display("FAIL random_flags got abort=%0d ovf=%0d exp %0d 0", abort_cnt, ovf_cnt, exp_aborts);
    end
  endtask

  initial begin
    bus.rx_bit   = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_sof   = 1'b0;
    bus.cw_ready = 1'b1;
    rst          = 1'b1;
    test_reset();
    test_clean_frame();
    test_backpressure();
    test_same_cycle_drain();
    test_mid_frame_sof();
    test_timeout();
    test_reset_mid_frame();
`ifdef HAM_RX_SYNDROME_EN
    test_syndrome();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
